// File: rtl/imm_gen_unit.sv
// Pipelined immediate generator: extracts an IR field, applies an extension mode or joins it
// with a latched prefix, and registers the result behind a valid/ready handshake.
module imm_gen_unit #(
    parameter int IR_W    = 32,
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int IMM_LSB = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IR_W-1:0]   ir,
    input  logic [2:0]        ext_mode,
    input  logic              prefix,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm_out,
    output logic              mode_err,
    output logic              prefix_pending
);

    typedef enum logic {
        IDLE     = 1'b0,
        PREFIXED = 1'b1
    } state_t;

    state_t             state;
    logic [IMM_W-1:0]   prefix_reg;
    logic [IMM_W-1:0]   field_p0;
    logic [DATA_W-1:0]  result_p0;
    logic               err_p0;
    logic               accept;

    function automatic logic [DATA_W-1:0] sign_ext(input logic [IMM_W-1:0] f);
        return {{(DATA_W-IMM_W){f[IMM_W-1]}}, f};
    endfunction

    function automatic logic [DATA_W-1:0] zero_ext(input logic [IMM_W-1:0] f);
        return {{(DATA_W-IMM_W){1'b0}}, f};
    endfunction

    // Field moved into the upper half; the cast zero-extends or truncates to DATA_W.
    function automatic logic [DATA_W-1:0] high_ext(input logic [IMM_W-1:0] f);
        return DATA_W'({f, {IMM_W{1'b0}}});
    endfunction

    function automatic logic [DATA_W-1:0] branch_ext(input logic [IMM_W-1:0] f);
        return sign_ext(f) << 2;
    endfunction

    function automatic logic [DATA_W-1:0] join_ext(input logic [IMM_W-1:0] p,
                                                   input logic [IMM_W-1:0] f);
        logic signed [2*IMM_W-1:0] joined;
        joined = {p, f};
        return DATA_W'(joined);
    endfunction

    assign in_ready       = !out_valid || out_ready;
    assign accept         = in_valid && in_ready && !flush;
    assign prefix_pending = (state == PREFIXED);
    assign field_p0       = ir[IMM_LSB+IMM_W-1 -: IMM_W];

    // Stage p0: extension datapath, purely from the current instruction and latched prefix.
    always_comb begin
        result_p0 = sign_ext(field_p0);
        err_p0    = 1'b0;
        if (state == PREFIXED) begin
            result_p0 = join_ext(prefix_reg, field_p0);
        end else begin
            case (ext_mode)
                3'd0:    result_p0 = sign_ext(field_p0);
                3'd1:    result_p0 = zero_ext(field_p0);
                3'd2:    result_p0 = high_ext(field_p0);
                3'd3:    result_p0 = branch_ext(field_p0);
                default: begin
                    result_p0 = sign_ext(field_p0);
                    err_p0    = 1'b1;
                end
            endcase
        end
    end

    // Stage p1: output register and prefix FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prefix_reg <= '0;
            out_valid  <= 1'b0;
            imm_out    <= '0;
            mode_err   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            state     <= IDLE;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (prefix) begin
                    prefix_reg <= field_p0;
                    state      <= PREFIXED;
                end else begin
                    out_valid <= 1'b1;
                    imm_out   <= result_p0;
                    mode_err  <= err_p0;
                    state     <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_unit.sv
// Bench for imm_gen_unit: directed vector table, hand-written handshake/prefix/flush/reset
// sequences, and randomized traffic against an arithmetic reference model.
module tb_imm_gen_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ir;
    logic [2:0]  ext_mode;
    logic        prefix;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imm_out;
    logic        mode_err;
    logic        prefix_pending;

    int tests = 0;
    int fails = 0;

    imm_gen_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ir            (ir),
        .ext_mode      (ext_mode),
        .prefix        (prefix),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .imm_out       (imm_out),
        .mode_err      (mode_err),
        .prefix_pending(prefix_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [2:0]  mode;
        logic [31:0] exp_imm;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: result of one non-prefix instruction, from the extension rules in plain arithmetic.
    function automatic logic [32:0] ref_result(input logic [31:0] word, input logic [2:0] mode,
                                               input bit pend, input logic [15:0] pre);
        longint f, sf, r;
        bit     err;
        f   = longint'((word >> 6) & 32'hFFFF);
        sf  = (f >= 32768) ? f - 65536 : f;
        err = 1'b0;
        if (pend) begin
            r = longint'(pre) * 65536 + f;
        end else begin
            case (mode)
                3'd0:    r = sf;
                3'd1:    r = f;
                3'd2:    r = f * 65536;
                3'd3:    r = sf * 4;
                default: begin r = sf; err = 1'b1; end
            endcase
        end
        return {err, r[31:0]};
    endfunction

    task automatic idle_inputs();
        in_valid  = 1'b0;
        prefix    = 1'b0;
        flush     = 1'b0;
        ext_mode  = 3'd0;
        ir        = 32'h0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    bit          m_valid, m_pend, acc, exp_rdy;
    logic [15:0] m_pre;
    logic [31:0] m_imm;
    logic        m_err;
    logic [32:0] r;
    logic [31:0] held;

    initial begin
        vecs[0] = '{32'h00200040, 3'd0, 32'hFFFF8001, 1'b0};
        vecs[1] = '{32'h00200040, 3'd1, 32'h00008001, 1'b0};
        vecs[2] = '{32'h00200040, 3'd2, 32'h80010000, 1'b0};
        vecs[3] = '{32'h00200040, 3'd3, 32'hFFFE0004, 1'b0};
        vecs[4] = '{32'h00200040, 3'd5, 32'hFFFF8001, 1'b1};
        vecs[5] = '{32'h00048D00, 3'd0, 32'h00001234, 1'b0};

        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset imm_out", imm_out, 32'h0);
        check("reset mode_err", 32'(mode_err), 32'd0);
        check("reset prefix_pending", 32'(prefix_pending), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Back-to-back table vectors, each result one cycle after its accept.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            ir       = vecs[i].ir;
            ext_mode = vecs[i].mode;
            cyc();
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d imm_out", i), imm_out, vecs[i].exp_imm);
            check($sformatf("vec%0d mode_err", i), 32'(mode_err), 32'(vecs[i].exp_err));
        end
        idle_inputs();
        cyc();
        check("drain out_valid", 32'(out_valid), 32'd0);

        // Prefix pair yields one joined output.
        in_valid = 1'b1; prefix = 1'b1; ir = 32'h00048D00;
        cyc();
        check("prefix no output", 32'(out_valid), 32'd0);
        check("prefix pending set", 32'(prefix_pending), 32'd1);
        idle_inputs();
        cyc();
        check("prefix pending held", 32'(prefix_pending), 32'd1);
        check("prefix gap no output", 32'(out_valid), 32'd0);
        in_valid = 1'b1; ir = 32'h00159E00; ext_mode = 3'd1;
        cyc();
        check("joined out_valid", 32'(out_valid), 32'd1);
        check("joined imm_out", imm_out, 32'h12345678);
        check("joined mode_err", 32'(mode_err), 32'd0);
        check("joined pending clear", 32'(prefix_pending), 32'd0);
        idle_inputs();
        cyc();
        check("joined single output", 32'(out_valid), 32'd0);

        // Backpressure holds the result, then releases straight into the next one.
        in_valid = 1'b1; ir = 32'h00200040; ext_mode = 3'd1; out_ready = 1'b0;
        cyc();
        check("bp first valid", 32'(out_valid), 32'd1);
        ir = 32'h00048D00; ext_mode = 3'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
            cyc();
            check($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d imm stable", i), imm_out, 32'h00008001);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        cyc();
        check("bp next valid", 32'(out_valid), 32'd1);
        check("bp next imm", imm_out, 32'h00001234);
        idle_inputs();
        cyc();
        check("bp no duplicate", 32'(out_valid), 32'd0);

        // Flush while a prefix is pending drops the input and the prefix.
        in_valid = 1'b1; prefix = 1'b1; ir = 32'h00048D00;
        cyc();
        prefix = 1'b0; flush = 1'b1; ir = 32'h00200040;
        cyc();
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush pending", 32'(prefix_pending), 32'd0);
        flush = 1'b0; ir = 32'h00159E00; ext_mode = 3'd0;
        cyc();
        check("post flush imm", imm_out, 32'h00005678);
        check("post flush valid", 32'(out_valid), 32'd1);
        idle_inputs();
        cyc();

        // Async reset between edges while a result is held.
        in_valid = 1'b1; ir = 32'h00200040; ext_mode = 3'd5; out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("arst out_valid", 32'(out_valid), 32'd0);
        check("arst imm_out", imm_out, 32'h0);
        check("arst mode_err", 32'(mode_err), 32'd0);
        cyc();
        rst_n = 1'b1; out_ready = 1'b1;
        cyc();
        check("arst no spurious output", 32'(out_valid), 32'd0);

        // Async reset between edges while a prefix is pending.
        in_valid = 1'b1; prefix = 1'b1; ir = 32'h00048D00;
        cyc();
        idle_inputs();
        #3 rst_n = 1'b0;
        #1;
        check("arst prefix_pending", 32'(prefix_pending), 32'd0);
        cyc();
        rst_n = 1'b1;
        in_valid = 1'b1; ir = 32'h00159E00; ext_mode = 3'd2;
        cyc();
        check("arst prefix discarded", imm_out, 32'h56780000);
        idle_inputs();
        do_reset();

        // Randomized traffic against the reference model.
        m_valid = 1'b0; m_pend = 1'b0; m_pre = '0; m_imm = '0; m_err = 1'b0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            prefix    = ($urandom_range(3) == 0);
            ext_mode  = 3'($urandom_range(7));
            ir        = $urandom;
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(15) == 0);
            #1;
            exp_rdy = !m_valid || out_ready;
            check("rand in_ready", 32'(in_ready), 32'(exp_rdy));
            acc = in_valid && exp_rdy && !flush;
            if (flush) begin
                m_valid = 1'b0;
                m_pend  = 1'b0;
            end else begin
                if (out_ready) m_valid = 1'b0;
                if (acc && prefix) begin
                    m_pre  = ir[21:6];
                    m_pend = 1'b1;
                end else if (acc) begin
                    r       = ref_result(ir, ext_mode, m_pend, m_pre);
                    m_imm   = r[31:0];
                    m_err   = r[32];
                    m_valid = 1'b1;
                    m_pend  = 1'b0;
                end
            end
            held = imm_out;
            cyc();
            check("rand out_valid", 32'(out_valid), 32'(m_valid));
            check("rand prefix_pending", 32'(prefix_pending), 32'(m_pend));
            if (m_valid) begin
                check("rand imm_out", imm_out, m_imm);
                check("rand mode_err", 32'(mode_err), 32'(m_err));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_gen_unit.md
Name: imm_gen_unit

Overview:
Parametrised, pipelined immediate generator. Successor to the combinational extend block between instruction register and ALU B-mux. Extracts a configurable immediate field from the instruction word and applies one of several extension modes. Adds a prefix mechanism that builds wide immediates from two instructions. Result is registered behind a valid/ready handshake so the block can sit in a pipeline stage.

Parameters:
IR_W, 32, instruction word width
DATA_W, 32, output datapath width; must be >= IMM_W+2
IMM_W, 16, immediate field width
IMM_LSB, 6, bit position of the field LSB in IR; IMM_LSB+IMM_W <= IR_W

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction word presented
in_ready  output  1  block can accept this cycle
ir  input  IR_W  instruction word
ext_mode  input  3  extension mode select
prefix  input  1  this instruction is an immediate prefix
flush  input  1  synchronous pipeline flush
out_valid  output  1  imm_out holds a valid result
out_ready  input  1  consumer accepts imm_out
imm_out  output  DATA_W  extended immediate
mode_err  output  1  result was produced from a reserved ext_mode
prefix_pending  output  1  a prefix is latched, awaiting its consumer

Behaviour:
- Reset (rst_n low, async): out_valid=0, imm_out=0, mode_err=0, prefix_pending=0, prefix_reg=0, FSM=IDLE.
- field = ir[IMM_LSB+IMM_W-1 : IMM_LSB]. accept = in_valid && in_ready && !flush.
- in_ready = !out_valid || out_ready (combinational). Provides full throughput with a single output register.
- Output register: loads on accept of a non-prefix instruction. out_valid set the following cycle, so latency is 1 cycle. While out_valid && !out_ready, imm_out and mode_err hold stable. out_valid clears when out_ready is high and no new result loads.
- ext_mode (applied in IDLE only):
  - 0: sign-extend field.
  - 1: zero-extend field.
  - 2: high, field << IMM_W, low bits zero, truncated/zero-extended to DATA_W.
  - 3: branch, sign-extended field << 2, truncated to DATA_W.
  - 4-7: reserved. Produce the sign-extend result and set mode_err=1 with that result.
  - mode_err=0 for modes 0-3.
- FSM states IDLE and PREFIXED. prefix_pending = (state==PREFIXED).
  - IDLE, accept && prefix: prefix_reg <= field; go to PREFIXED; no output produced.
  - IDLE, accept && !prefix: output per ext_mode; stay in IDLE.
  - PREFIXED, accept && prefix: prefix_reg overwritten; stay in PREFIXED.
  - PREFIXED, accept && !prefix: imm_out = {prefix_reg, field} sign-extended from bit 2*IMM_W-1 (or truncated) to DATA_W. ext_mode is ignored and mode_err=0. Return to IDLE.
- A prefix is always accepted when in_ready, even if the output register is holding data.
- flush (synchronous, highest priority over accept):
  - out_valid <= 0 and FSM <= IDLE. prefix_reg is left unchanged but unused.
  - Any input presented that cycle is dropped.
  - imm_out value after flush is don't-care; the bench checks only out_valid.
- Reset asserted mid-operation clears everything immediately. No output is produced until after rst_n deassert and a new accept.
- No combinational path from ir to imm_out.

Test Plan:
(Default parameters assumed.)
- Modes 0/1/2/3 with ir=0x00200040 (field 0x8001), out_ready=1 -> imm_out 0xFFFF8001, 0x00008001, 0x80010000, 0xFFFE0004, each one cycle after accept; mode_err=0.
- ext_mode=5, ir=0x00200040 -> imm_out=0xFFFF8001 and mode_err=1. Next mode 0 result -> mode_err=0.
- Prefix ir=0x00048D00 (0x1234), then ir=0x00159E00 (0x5678) with ext_mode=1 -> only one output, 0x12345678. prefix_pending high for exactly the cycles between the two accepts.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0 and imm_out stable. Raise out_ready with a new in_valid the same cycle -> back-to-back results, no loss or duplicate.
- Flush in PREFIXED with in_valid=1 -> input dropped, out_valid=0, prefix_pending=0. Next ir=0x00159E00 in mode 0 -> 0x00005678.
- Assert rst_n low asynchronously between clock edges while out_valid=1 and PREFIXED -> out_valid, imm_out, mode_err and prefix_pending go to 0 immediately.
